// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: SELECT codes, default per-class
// latencies, FSM state encoding and latency helpers.
package alu_scheduler_pkg;

    typedef enum logic [2:0] {
        OP_FWD = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLL = 3'b100,
        OP_SRL = 3'b101,
        OP_MUL = 3'b110,
        OP_ROR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        CLS_SIMPLE = 2'd0,
        CLS_SHIFT  = 2'd1,
        CLS_MUL    = 2'd2
    } op_class_e;

    localparam int unsigned LAT_SIMPLE_DEF = 32'd1;
    localparam int unsigned LAT_SHIFT_DEF  = 32'd2;
    localparam int unsigned LAT_MUL_DEF    = 32'd3;

    function automatic op_class_e op_class(input logic [2:0] op);
        op_class_e cls;
        case (op)
            OP_SLL, OP_SRL, OP_ROR: cls = CLS_SHIFT;
            OP_MUL:                 cls = CLS_MUL;
            default:                cls = CLS_SIMPLE;
        endcase
        return cls;
    endfunction

    // A zero latency behaves as one cycle; anything past the counter range saturates.
    function automatic logic [3:0] lat_clamp(input int unsigned lat);
        logic [3:0] res;
        if (lat == 32'd0) begin
            res = 4'd1;
        end else if (lat > 32'd15) begin
            res = 4'd15;
        end else begin
            res = lat[3:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester, ALU and response signals of the scheduler, bundled as one bus.
interface alu_scheduler_if;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_op;
    logic [1:0][7:0]  req_a;
    logic [1:0][7:0]  req_b;

    logic [7:0]       alu_data1;
    logic [7:0]       alu_data2;
    logic [2:0]       alu_select;
    logic [7:0]       alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic             rsp_zero;
    logic             rsp_id;
    logic             busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_data1, alu_data2, alu_select,
               rsp_valid, rsp_result, rsp_zero, rsp_id, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_data1, alu_data2, alu_select,
               rsp_valid, rsp_result, rsp_zero, rsp_id, busy
    );

endinterface

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    // One-hot grant selection, suppressed outside IDLE
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (valid_i[0] && (!valid_i[1] || last_i)) begin
                grant_o = 2'b01;
            end else if (valid_i[1]) begin
                grant_o = 2'b10;
            end else begin
                grant_o = 2'b00;
            end
        end else begin
            grant_o = 2'b00;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU between two requesters: accepts one operation, drives the ALU
// from registers, waits the operation-class latency and holds a tagged response.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int unsigned LAT_SIMPLE = LAT_SIMPLE_DEF,
    parameter int unsigned LAT_SHIFT  = LAT_SHIFT_DEF,
    parameter int unsigned LAT_MUL    = LAT_MUL_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    alu_scheduler_if.slave  bus
);

    // CNT counts the remaining settle edges after the first one.
    localparam logic [3:0] CNT_SIMPLE = lat_clamp(LAT_SIMPLE) - 4'd1;
    localparam logic [3:0] CNT_SHIFT  = lat_clamp(LAT_SHIFT)  - 4'd1;
    localparam logic [3:0] CNT_MUL    = lat_clamp(LAT_MUL)    - 4'd1;

    sched_state_e state_q;
    logic [3:0]   cnt_q;
    logic         last_q;
    logic         id_q;
    logic         busy_q;
    logic [7:0]   alu_data1_q;
    logic [7:0]   alu_data2_q;
    logic [2:0]   alu_select_q;
    logic         rsp_valid_q;
    logic [7:0]   rsp_result_q;
    logic         rsp_zero_q;
    logic         rsp_id_q;

    logic [1:0]   grant_s;
    logic         gnt_idx_s;
    logic [2:0]   gnt_op_s;
    logic [3:0]   cnt_load_s;

    rr_arbiter2 u_arb (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .en_i    (state_q == ST_IDLE),
        .grant_o (grant_s)
    );

    assign gnt_idx_s = grant_s[1];
    assign gnt_op_s  = bus.req_op[gnt_idx_s];

    // Initial wait count for the granted operation's class
    always_comb begin
        cnt_load_s = CNT_SIMPLE;
        case (op_class(gnt_op_s))
            CLS_SIMPLE: cnt_load_s = CNT_SIMPLE;
            CLS_SHIFT:  cnt_load_s = CNT_SHIFT;
            CLS_MUL:    cnt_load_s = CNT_MUL;
            default:    cnt_load_s = CNT_SIMPLE;
        endcase
    end

    // Scheduler FSM with its registered ALU and response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            busy_q       <= 1'b0;
            alu_data1_q  <= 8'h00;
            alu_data2_q  <= 8'h00;
            alu_select_q <= 3'b000;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 8'h00;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        alu_data1_q  <= bus.req_a[gnt_idx_s];
                        alu_data2_q  <= bus.req_b[gnt_idx_s];
                        alu_select_q <= gnt_op_s;
                        id_q         <= gnt_idx_s;
                        last_q       <= gnt_idx_s;
                        cnt_q        <= cnt_load_s;
                        busy_q       <= 1'b1;
                        state_q      <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_result_q <= bus.alu_result;
                        rsp_zero_q   <= bus.alu_zero;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cnt_q       <= 4'd0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is held low throughout reset even though the state reads IDLE.
    assign bus.req_ready  = grant_s & {2{rst_ni}};
    assign bus.alu_data1  = alu_data1_q;
    assign bus.alu_data2  = alu_data2_q;
    assign bus.alu_select = alu_select_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and arbiter that shares the single 8-bit `alu` datapath between two requesters, such as the CPU issue stage and a second client. It accepts one operation at a time through a valid/ready handshake and drives the ALU operand and select lines from registers. It waits a per-operation-class number of cycles for the ALU to settle, then captures RESULT/ZERO into a held response tagged with the requester ID. It sits between the requesters and the `alu` instance, and owns `alu`'s DATA1, DATA2 and SELECT inputs.

## Interface
Parameters:
- LAT_SIMPLE, 1, cycles for forward/add/and/or (SELECT 000–011)
- LAT_SHIFT, 2, cycles for left/right shift and rotate (100, 101, 111)
- LAT_MUL, 3, cycles for multiply (110)
- All latencies are legal in 1–15. A value of 0 is treated as 1.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- REQ0_VALID / REQ1_VALID  in  1  requester has an operation
- REQ0_READY / REQ1_READY  out  1  operation accepted this cycle
- REQ0_OP / REQ1_OP  in  3  ALU SELECT code
- REQ0_A / REQ1_A  in  8  operand DATA1
- REQ0_B / REQ1_B  in  8  operand DATA2
- ALU_DATA1, ALU_DATA2  out  8  registered operands to `alu`
- ALU_SELECT  out  3  registered select to `alu`
- ALU_RESULT  in  8  `alu` RESULT
- ALU_ZERO  in  1  `alu` ZERO
- RSP_VALID  out  1  response available
- RSP_READY  in  1  consumer takes response
- RSP_RESULT  out  8  captured result
- RSP_ZERO  out  1  captured ZERO
- RSP_ID  out  1  requester that issued the operation
- BUSY  out  1  high whenever the state is not IDLE

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE:**
  - If any REQx_VALID is high, the arbiter grants one requester. REQx_READY is combinational and high only for the granted requester, only in IDLE.
  - On the accept edge: latch OP/A/B onto the ALU_* registers, latch the ID, load CNT = LAT(op) − 1, and go to WAIT.
- **WAIT:**
  - If CNT ≠ 0, decrement CNT.
  - If CNT = 0, capture ALU_RESULT → RSP_RESULT and ALU_ZERO → RSP_ZERO, set RSP_VALID, and go to RESP.
- **RESP:**
  - RSP_* are held stable while RSP_READY is low.
  - When RSP_VALID & RSP_READY, clear RSP_VALID and go to IDLE.
- **Arbitration:** two-way round-robin.
  - A single valid requester always wins.
  - When both are valid, the grant goes to the requester not granted last.
  - LAST is updated only on accept.
- ALU_* registers hold their value after capture, until the next accept.
- All eight SELECT codes are legal. The scheduler does not inspect operands. Shift amount is the ALU's DATA2[2:0].
- CNT is 4 bits wide.

## Timing
- Reset values (while RESET = 0, asynchronously):
  - state IDLE, CNT 0, LAST = 1, so requester 0 wins the first tie
  - ALU_DATA1/ALU_DATA2 8'h00, ALU_SELECT 3'b000
  - RSP_VALID 0, RSP_RESULT 8'h00, RSP_ZERO 0, RSP_ID 0
  - BUSY 0; REQx_READY 0 on the cycles where RESET is low
- Latency: accept at edge T → RSP_VALID high after edge T+LAT(op).
- Throughput: the earliest next accept is the edge after the response handshake. Accept and response never coincide.
- VALID/OP/A/B changes on a non-accepted requester have no effect.
- Reset mid-WAIT or mid-RESP drops the operation. No response is produced after release.
- The clock period must cover the `alu` worst-case combinational delay for LAT_SIMPLE = 1.

## Structure
- Shared header `alu_ops.vh` holds:
  - SELECT code constants (FWD 000, ADD 001, AND 010, OR 011, SLL 100, SRL 101, MUL 110, ROR 111)
  - default latency constants
  - FSM state encodings
- One sub-module, `rr_arbiter2`:
  - inputs: two valids, LAST, enable (state == IDLE)
  - outputs: one-hot grant
  - combinational
- LAST and the FSM stay in `alu_scheduler`.

## Test plan
- **Single ADD.** After reset, REQ0 ADD with A=5, B=3 → REQ0_READY high one cycle; RSP_VALID after 1 edge with RESULT 8'd8, ZERO 0, ID 0.
- **MUL latency.** REQ1 MUL with A=4, B=3 → RSP_VALID exactly 3 edges after accept, RESULT 8'd12, ID 1. BUSY is high for those 3 cycles plus the RESP cycles.
- **Tie and alternation.** Both requesters valid continuously from reset: REQ0 OR 0x0F|0xF0, REQ1 AND 0xF0&0x0F.
  - Grant order is 0, 1, 0, 1.
  - Responses are 8'hFF/ZERO 0/ID 0, then 8'h00/ZERO 1/ID 1.
- **Backpressure.** Hold RSP_READY low for 5 cycles after RSP_VALID → RSP_RESULT/ZERO/ID stay stable, both REQx_READY stay low, no new accept. The response completes on the first RSP_READY high.
- **Reset mid-operation.** Accept MUL, then drive RESET low on the second WAIT cycle → all outputs go to reset values immediately. After release, RSP_VALID stays 0 with no pending request.
- **Shift.** REQ0 SLL with A=8'h01, B=3 → RSP_VALID after 2 edges, RESULT 8'h08. ALU_SELECT reads 3'b100 throughout WAIT and RESP.
